// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-N up/down counter with prescaler, load/clear, terminal-count pulse and sticky overflow.
// Define COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module mod_updown_counter #(
   parameter int     WIDTH    = 8,
   parameter longint MODULUS  = 256,
   parameter int     PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] qout,
   output logic             tc,
   output logic             ovf
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
   localparam logic [PW-1:0] PSC_MAX = PW'(PRESCALE - 1);
   logic [PW-1:0] psc, psc_nxt;
   logic [WIDTH-1:0] q_step, q_nxt;
   logic step, edge_hit, tc_nxt, ovf_nxt;
   always_comb begin
      step = en && psc == PSC_MAX;
      edge_hit = up ? qout == MAX : qout == '0;
`ifdef COUNTER_SAT_EN
      q_step = edge_hit ? qout : (up ? qout + 1'b1 : qout - 1'b1);
`else
      q_step = up ? (edge_hit ? '0 : qout + 1'b1) : (edge_hit ? MAX : qout - 1'b1);
`endif
      psc_nxt = (clr || load) ? '0 : en ? (step ? '0 : psc + 1'b1) : psc;
      q_nxt = clr ? '0 : load ? (load_val > MAX ? MAX : load_val) : step ? q_step : qout;
      // clear/load pre-empt a coincident terminal step, so it neither pulses nor sets ovf
      tc_nxt = !clr && !load && step && edge_hit;
      ovf_nxt = !clr && (ovf || tc_nxt);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         qout <= '0;
         psc  <= '0;
         tc   <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         qout <= q_nxt;
         psc  <= psc_nxt;
         tc   <= tc_nxt;
         ovf  <= ovf_nxt;
      end
   end
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: scoreboarded random/directed bench for three counter configurations.
module tb_mod_updown_counter;
`ifdef COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   localparam int P  [3] = '{1, 4, 3};
   localparam int M  [3] = '{10, 10, 16};
   localparam int LM [3] = '{255, 255, 15};
   typedef struct packed {
      logic [2:0][7:0] q;
      logic [2:0]      tc;
      logic [2:0]      ovf;
   } exp_t;
   logic clk = 1'b0, reset_n = 1'b1, clr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b1;
   logic [7:0] load_val = '0;
   logic [7:0] q0, q1;
   logic [3:0] q2;
   logic [2:0] tc, ovf;
   logic [7:0] qa [3];
   exp_t sb [$];
   int mq [3], mpsc [3];
   bit mtc [3], movf [3];
   int checks = 0, errors = 0;
   assign qa[0] = q0;
   assign qa[1] = q1;
   assign qa[2] = {4'b0, q2};
   mod_updown_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(1)) u0 (
      .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up(up), .qout(q0), .tc(tc[0]), .ovf(ovf[0]));
   mod_updown_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(4)) u1 (
      .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up(up), .qout(q1), .tc(tc[1]), .ovf(ovf[1]));
   mod_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) u2 (
      .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val[3:0]),
      .en(en), .up(up), .qout(q2), .tc(tc[2]), .ovf(ovf[2]));
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask
   // Reference model: count range arithmetic done modulo M, prescaler as an enabled-edge tally
   task automatic model(input bit c, input bit l, input bit e, input bit u, input int v);
      for (int i = 0; i < 3; i++) begin
         if (c) begin
            mq[i] = 0; mpsc[i] = 0; mtc[i] = 0; movf[i] = 0;
         end else if (l) begin
            mq[i] = (v & LM[i]) > M[i] - 1 ? M[i] - 1 : (v & LM[i]);
            mpsc[i] = 0; mtc[i] = 0;
         end else if (!e) begin
            mtc[i] = 0;
         end else if (mpsc[i] + 1 < P[i]) begin
            mpsc[i]++; mtc[i] = 0;
         end else begin
            mpsc[i] = 0;
            mtc[i] = u ? mq[i] == M[i] - 1 : mq[i] == 0;
            if (mtc[i]) movf[i] = 1;
            if (!(mtc[i] && SAT)) mq[i] = (mq[i] + (u ? 1 : M[i] - 1)) % M[i];
         end
      end
   endtask
   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mq[i] = 0; mpsc[i] = 0; mtc[i] = 0; movf[i] = 0;
      end
   endtask
   task automatic drive(input bit c, input bit l, input bit e, input bit u, input int v);
      exp_t x;
      clr = c; load = l; en = e; up = u; load_val = 8'(v);
      model(c, l, e, u, v);
      for (int i = 0; i < 3; i++) begin
         x.q[i] = 8'(mq[i]);
         x.tc[i] = mtc[i];
         x.ovf[i] = movf[i];
      end
      sb.push_back(x);
      @(negedge clk);
   endtask
   task automatic check_zero(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_q%0d", tag, i), int'(qa[i]), 0);
         chk($sformatf("%s_tc%0d", tag, i), int'(tc[i]), 0);
         chk($sformatf("%s_ovf%0d", tag, i), int'(ovf[i]), 0);
      end
   endtask
   // Idle one edge, then pull reset_n low between edges and look before any clock
   task automatic areset();
      clr = 0; load = 0; en = 0;
      model(0, 0, 0, up, 0);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1 check_zero("async_rst");
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask
   initial forever begin
      exp_t x;
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         x = sb.pop_front();
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("q%0d", i), int'(qa[i]), int'(x.q[i]));
            chk($sformatf("tc%0d", i), int'(tc[i]), int'(x.tc[i]));
            chk($sformatf("ovf%0d", i), int'(ovf[i]), int'(x.ovf[i]));
         end
      end
   end
   initial begin
      bit dir = 1'b1;
      model_reset();
      #1 reset_n = 1'b0;
      #1 check_zero("por");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) drive(0, 0, 1, 1, 0);
      areset();
      repeat (13) drive(0, 0, 1, 1, 0);
      drive(1, 0, 0, 1, 0);
      repeat (2) drive(0, 0, 1, 0, 0);
      drive(1, 0, 0, 1, 0);
      drive(0, 0, 1, 1, 0);
      drive(0, 0, 1, 1, 0);
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 1, 1, 0);
      drive(0, 0, 1, 1, 0);
      drive(0, 1, 1, 1, 200);
      drive(1, 1, 1, 1, 200);
      drive(0, 1, 0, 1, 200);
      repeat (12) drive(0, 0, 1, 1, 0);
      areset();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) < 10) dir = ~dir;
         if ($urandom_range(0, 199) == 0) areset();
         drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6,
               $urandom_range(0, 99) < 75, dir, int'($urandom_range(0, 255)));
      end
      clr = 0; load = 0; en = 0;
      for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
